// File: rtl/alu_pkg.sv
// Shared encodings for the digit-serial ALU: operation codes, FSM states and
// bit positions inside the readback flags byte.
package alu_pkg;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_NAND = 2'd2;
    localparam logic [1:0] OP_XOR  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;

endpackage

// File: rtl/digit_slice.sv
// One DIGIT-bit combinational slice: ripple-carry add/subtract or a bitwise
// logic op. For logic ops the carry passes straight through.
module digit_slice
    import alu_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    input  logic [1:0]       i_op,
    output logic [DIGIT-1:0] o_r,
    output logic             o_cout
);

    logic [DIGIT-1:0] w_bx;

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin : slice_logic
        logic w_c;
        w_bx   = (i_op == OP_SUB) ? ~i_b : i_b;
        w_c    = i_cin;
        o_r    = '0;
        o_cout = i_cin;
        case (i_op)
            OP_ADD, OP_SUB: begin
                for (int i = 0; i < DIGIT; i++) begin
                    o_r[i] = i_a[i] ^ w_bx[i] ^ w_c;
                    w_c    = (i_a[i] & w_bx[i]) | (w_c & (i_a[i] ^ w_bx[i]));
                end
                o_cout = w_c;
            end
            OP_NAND: o_r = ~(i_a & i_b);
            default: o_r = i_a ^ i_b;
        endcase
    end

endmodule

// File: rtl/digit_serial_alu.sv
// Digit-serial ALU test vehicle: byte-wise operand load, LSB-digit-first
// multi-cycle compute with start/busy/done, registered byte-wise readback.
module digit_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        data_in,
    input  logic                              wr_en,
    input  logic [$clog2(2*(WIDTH/8))-1:0]    wr_sel,
    input  logic [1:0]                        op,
    input  logic                              start,
    input  logic [$clog2(WIDTH/8+1)-1:0]      rd_sel,
    output logic [7:0]                        data_out,
    output logic                              busy,
    output logic                              done
);

    localparam int NBYTES = WIDTH / 8;
    localparam int NDIG   = WIDTH / DIGIT;
    localparam int WSEL_W = $clog2(2*NBYTES);
    localparam int RSEL_W = $clog2(NBYTES+1);
    localparam int CNT_W  = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_a, r_b, r_wa, r_wb, r_res;
    logic [1:0]         r_op;
    logic               r_carry, r_zero, r_zero_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_dout;

    logic               w_not_run, w_launch, w_wr_ok, w_last, w_dzero;
    logic [DIGIT-1:0]   w_r;
    logic               w_cout;
    logic [WIDTH+DIGIT-1:0] w_res_cat;
    logic [7:0]         w_rd_byte;

    assign w_not_run = (r_state != S_RUN);
    assign w_launch  = start & w_not_run;
    // A simultaneous start takes priority, so the write is dropped.
    assign w_wr_ok   = wr_en & w_not_run & ~start
                     & ({1'b0, wr_sel} < (WSEL_W+1)'(2*NBYTES));
    assign w_last    = (r_cnt == CNT_W'(NDIG-1));
    assign w_dzero   = (w_r == '0);
    assign w_res_cat = {w_r, r_res};

    digit_slice #(.DIGIT(DIGIT)) u_slice (
        .i_a    (r_wa[DIGIT-1:0]),
        .i_b    (r_wb[DIGIT-1:0]),
        .i_cin  (r_carry),
        .i_op   (r_op),
        .o_r    (w_r),
        .o_cout (w_cout)
    );

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state == S_RUN);
        done        = (r_state == S_DONE);
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_RUN;
            S_RUN:  if (w_last) w_state_nxt = S_DONE;
            S_DONE: begin
                if (start)        w_state_nxt = S_RUN;
                else if (w_wr_ok) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_wa       <= '0;
            r_wb       <= '0;
            r_res      <= '0;
            r_op       <= OP_ADD;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
            r_zero_acc <= 1'b0;
            r_cnt      <= '0;
        end else if (w_launch) begin
            r_op       <= op;
            r_wa       <= r_a;
            r_wb       <= r_b;
            r_res      <= '0;
            r_carry    <= (op == OP_SUB);
            r_zero_acc <= 1'b1;
            r_cnt      <= '0;
        end else if (r_state == S_RUN) begin
            r_wa       <= r_wa >> DIGIT;
            r_wb       <= r_wb >> DIGIT;
            r_res      <= w_res_cat[WIDTH+DIGIT-1:DIGIT];
            r_carry    <= w_cout;
            r_zero_acc <= r_zero_acc & w_dzero;
            r_cnt      <= r_cnt + 1'b1;
            if (w_last) r_zero <= r_zero_acc & w_dzero;
        end else if (w_wr_ok) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (wr_sel == WSEL_W'(k))        r_a[k*8 +: 8] <= data_in;
                if (wr_sel == WSEL_W'(k+NBYTES)) r_b[k*8 +: 8] <= data_in;
            end
        end
    end

    always_comb begin
        w_rd_byte = '0;
        for (int k = 0; k < NBYTES; k++)
            if (rd_sel == RSEL_W'(k)) w_rd_byte = r_res[k*8 +: 8];
        if (rd_sel == RSEL_W'(NBYTES)) begin
            w_rd_byte[FLAG_CARRY] = r_carry;
            w_rd_byte[FLAG_ZERO]  = r_zero;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_dout <= '0;
        else     r_dout <= w_rd_byte;
    end

    assign data_out = r_dout;

endmodule

// File: tb/tb_digit_serial_alu.sv
// Self-checking bench: three instances (DIGIT=4, 1, 32) share stimulus; results
// are compared against a whole-word arithmetic reference model.
module tb_digit_serial_alu;

    localparam int W = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = '0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_sel = '0;
    logic [1:0] op = '0;
    logic       start = 1'b0;
    logic [2:0] rd_sel = '0;

    logic [7:0] dout [3];
    logic       busy [3];
    logic       done [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    digit_serial_alu #(.WIDTH(W), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .wr_sel(wr_sel),
        .op(op), .start(start), .rd_sel(rd_sel),
        .data_out(dout[0]), .busy(busy[0]), .done(done[0]));
    digit_serial_alu #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .wr_sel(wr_sel),
        .op(op), .start(start), .rd_sel(rd_sel),
        .data_out(dout[1]), .busy(busy[1]), .done(done[1]));
    digit_serial_alu #(.WIDTH(W), .DIGIT(32)) u_d32 (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .wr_sel(wr_sel),
        .op(op), .start(start), .rd_sel(rd_sel),
        .data_out(dout[2]), .busy(busy[2]), .done(done[2]));

    // Whole-word reference: result and flags byte {zero, carry}.
    function automatic void model(input logic [1:0] mop, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] res,
                                  output logic [7:0] flags);
        logic [32:0] wide;
        logic        c;
        case (mop)
            2'd0:    begin wide = {1'b0, a} + {1'b0, b}; res = wide[31:0]; c = wide[32]; end
            2'd1:    begin res = a - b; c = (a >= b); end
            2'd2:    begin res = ~(a & b); c = 1'b0; end
            default: begin res = a ^ b; c = 1'b0; end
        endcase
        flags = {6'b0, (res == 32'd0), c};
    endfunction

    // All helper tasks enter and leave on a falling edge.
    task automatic wr_byte(input int sel, input logic [7:0] v);
        wr_en = 1'b1; wr_sel = 3'(sel); data_in = v;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] b);
        for (int k = 0; k < 4; k++) wr_byte(k, a[k*8 +: 8]);
        for (int k = 0; k < 4; k++) wr_byte(k + 4, b[k*8 +: 8]);
    endtask

    task automatic launch(input logic [1:0] o);
        op = o; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int idx, output int cycles);
        cycles = 0;
        while (busy[idx] === 1'b1 && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        n_checks++;
        if (done[idx] !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_done[%0d]: done=%b after %0d busy cycles, required 1", idx, done[idx], cycles);
        end
    endtask

    task automatic read_all(input int idx, output logic [31:0] res, output logic [7:0] flags);
        for (int s = 0; s < 5; s++) begin
            rd_sel = 3'(s);
            @(negedge clk);
            if (s < 4) res[s*8 +: 8] = dout[idx];
            else       flags = dout[idx];
        end
    endtask

    task automatic check_result(input string name, input int idx,
                                input logic [31:0] exp_r, input logic [7:0] exp_f);
        logic [31:0] r;
        logic [7:0]  f;
        read_all(idx, r, f);
        n_checks++;
        if (r !== exp_r) begin
            n_fail++;
            $display("FAIL %s result: got %h, required %h", name, r, exp_r);
        end
        n_checks++;
        if (f !== exp_f) begin
            n_fail++;
            $display("FAIL %s flags: got %h, required %h", name, f, exp_f);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        int          cyc;
        logic [31:0] er;
        logic [7:0]  ef;
        load(a, b);
        launch(o);
        wait_done(0, cyc);
        n_checks++;
        if (cyc != 8) begin
            n_fail++;
            $display("FAIL %s busy cycles: got %0d, required 8", name, cyc);
        end
        model(o, a, b, er, ef);
        check_result(name, 0, er, ef);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0 || dout[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL reset outputs: busy=%b done=%b dout=%h, required 0 0 00", busy[0], done[0], dout[0]);
        end
        check_result("reset", 0, 32'h0, 8'h00);
    endtask

    task automatic test_directed;
        logic [31:0] r;
        logic [7:0]  f;
        run_op("add_ovf", 2'd0, 32'hFFFF_FFFF, 32'h0000_0001);
        check_result("add_ovf_lit", 0, 32'h0000_0000, 8'h03);
        run_op("sub_borrow", 2'd1, 32'd5, 32'd7);
        check_result("sub_borrow_lit", 0, 32'hFFFF_FFFE, 8'h00);
        run_op("sub_equal", 2'd1, 32'd7, 32'd7);
        check_result("sub_equal_lit", 0, 32'h0, 8'h03);
        run_op("nand", 2'd2, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check_result("nand_lit", 0, 32'h0FFF_0FFF, 8'h00);
        run_op("xor", 2'd3, 32'hF0F0_F0F0, 32'hFF00_FF00);
        read_all(0, r, f);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (r[k*8 +: 8] !== ((k % 2 == 0) ? 8'hF0 : 8'h0F)) begin
                n_fail++;
                $display("FAIL xor byte %0d: got %h, required %h", k, r[k*8 +: 8], (k % 2 == 0) ? 8'hF0 : 8'h0F);
            end
        end
        rd_sel = 3'd5;
        @(negedge clk);
        n_checks++;
        if (dout[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL rd_sel out of range: got %h, required 00", dout[0]);
        end
        wr_byte(0, 8'hF0);
        n_checks++;
        if (done[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL write in DONE: done=%b, required 0", done[0]);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 20; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 5 == 0) ? a : $urandom;
            run_op("random", 2'($urandom_range(0, 3)), a, b);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, b, er;
        logic [7:0]  ef;
        int          cyc;
        a = $urandom; b = $urandom;
        load(a, b);
        launch(2'd0);
        @(negedge clk);
        @(negedge clk);
        wr_en = 1'b1; wr_sel = 3'd4; data_in = 8'hAA; start = 1'b1; op = 2'd3;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        wait_done(0, cyc);
        n_checks++;
        if (cyc != 5) begin
            n_fail++;
            $display("FAIL interference remaining busy: got %0d, required 5", cyc);
        end
        model(2'd0, a, b, er, ef);
        check_result("interference_add", 0, er, ef);
        launch(2'd3);
        wait_done(0, cyc);
        model(2'd3, a, b, er, ef);
        check_result("restart_xor_b_unchanged", 0, er, ef);
    endtask

    task automatic test_reset_midrun;
        int cyc;
        load(32'h1234_5678, 32'h9ABC_DEF0);
        launch(2'd0);
        rd_sel = 3'd3;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun busy before reset: got %b, required 1", busy[0]);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0 || dout[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL async reset: busy=%b done=%b dout=%h, required 0 0 00", busy[0], done[0], dout[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        launch(2'd0);
        wait_done(0, cyc);
        check_result("post_reset_add", 0, 32'h0, 8'h02);
    endtask

    task automatic test_digit_variants;
        int cnt [3];
        int exp_cnt [3];
        exp_cnt[0] = 8; exp_cnt[1] = 32; exp_cnt[2] = 1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        load(32'hFFFF_FFFF, 32'h0000_0001);
        launch(2'd0);
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < 3; i++) if (busy[i] === 1'b1) cnt[i]++;
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (cnt[i] != exp_cnt[i] || done[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL variant %0d busy: got %0d cycles done=%b, required %0d done=1", i, cnt[i], done[i], exp_cnt[i]);
            end
            check_result("variant_add", i, 32'h0, 8'h03);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midrun();
        test_digit_variants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
